// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one BLOCK-bit lookahead block per stage, skewed operands, deskewed sum, valid tag.
// Optional feature macro: ADDER_SUB_MODE_EN (adds the sub port for A - B).
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
`ifdef ADDER_SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned BLK    = (BLOCK < 1) ? 1 : BLOCK;
    localparam int unsigned STAGES = (WIDTH / BLK < 1) ? 1 : WIDTH / BLK;

    if (BLOCK < 1) begin : g_bad_block
        $error("pipelined_cla_adder: BLOCK must be at least 1");
    end
    if ((WIDTH == 0) || (WIDTH % BLK != 0)) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // c[i+1] as a flat sum of products over g/p terms, so no carry ripples inside a block
    function automatic logic [BLK:0] cla_carries(input logic [BLK-1:0] g,
                                                 input logic [BLK-1:0] p,
                                                 input logic           c0);
        logic [BLK:0] c;
        logic         term;
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 0; i < BLK; i++) begin
            term = c0;
            for (int unsigned m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // level 0 is the input register; level k+1 is written by stage k
    logic [WIDTH-1:0] a_q [0:STAGES-1];
    logic [WIDTH-1:0] b_q [0:STAGES-1];
    logic             c_q [0:STAGES];
    logic             v_q [0:STAGES];
    logic [WIDTH-1:0] s_q [1:STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef ADDER_SUB_MODE_EN
    // subtraction enters as A + ~B + 1 and then travels the ordinary add pipeline
    always_comb begin
        b_in = sub ? ~in2 : in2;
        c_in = cin | sub;
    end
`else
    always_comb begin
        b_in = in2;
        c_in = cin;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q[0] <= 1'b0;
            a_q[0] <= '0;
            b_q[0] <= '0;
            c_q[0] <= 1'b0;
        end else begin
            v_q[0] <= in_valid;
            a_q[0] <= in1;
            b_q[0] <= b_in;
            c_q[0] <= c_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [BLK-1:0]   blk_a;
        logic [BLK-1:0]   blk_b;
        logic [BLK-1:0]   blk_s;
        logic [BLK:0]     cc;
        logic [WIDTH-1:0] s_prev;
        logic [WIDTH-1:0] s_next;

        if (k == 0) begin : g_first
            always_comb s_prev = '0;
        end else begin : g_rest
            always_comb s_prev = s_q[k];
        end

        // operands shift down one block per stage; finished sum blocks enter at the top and shift down
        always_comb begin
            blk_a  = a_q[k][BLK-1:0];
            blk_b  = b_q[k][BLK-1:0];
            cc     = cla_carries(blk_a & blk_b, blk_a ^ blk_b, c_q[k]);
            blk_s  = (blk_a ^ blk_b) ^ cc[BLK-1:0];
            s_next = (s_prev >> BLK) | (WIDTH'(blk_s) << (WIDTH - BLK));
        end

        if (k < STAGES - 1) begin : g_mid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q[k+1] <= '0;
                    b_q[k+1] <= '0;
                    c_q[k+1] <= 1'b0;
                    v_q[k+1] <= 1'b0;
                    s_q[k+1] <= '0;
                end else begin
                    a_q[k+1] <= a_q[k] >> BLK;
                    b_q[k+1] <= b_q[k] >> BLK;
                    c_q[k+1] <= cc[BLK];
                    v_q[k+1] <= v_q[k];
                    s_q[k+1] <= s_next;
                end
            end
        end else begin : g_last
            // result registers load only for valid entries, so outputs hold across bubbles
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q[k+1] <= 1'b0;
                    s_q[k+1] <= '0;
                    c_q[k+1] <= 1'b0;
                    ovf_q    <= 1'b0;
                end else begin
                    v_q[k+1] <= v_q[k];
                    if (v_q[k]) begin
                        s_q[k+1] <= s_next;
                        c_q[k+1] <= cc[BLK];
                        ovf_q    <= cc[BLK] ^ cc[BLK-1];
                    end
                end
            end
        end
    end

    always_comb begin
        out_valid = v_q[STAGES];
        out       = s_q[STAGES];
        cout      = c_q[STAGES];
        ovf       = ovf_q;
    end

endmodule
